data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Responder side of the control unit's data-memory control signals: latches the memory-bank select and address from the shared 8-bit bus, performs synchronous single-port reads/writes into a banked data RAM, and drives read data back onto the bus with fixed one-cycle latency so microcode steps can be scheduled statically. It sits between the control unit / register bank bus and the data RAM and is the only owner of bank, address and read-data state.

## Interface
- DATA_WIDTH, 8, bus and word width
- ADDR_WIDTH, 8, in-bank address width (256 words/bank)
- BANK_WIDTH, 2, bank select width (4 banks, 1024 words total)

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_mbs_wr_enable  in  1  latch bank from in_bus[BANK_WIDTH-1:0]
- in_addr_wr_enable  in  1  latch address from in_bus
- in_read_enable  in  1  read word at {bank, addr}
- in_wr_enable  in  1  write in_bus to {bank, addr}
- in_bus  in  DATA_WIDTH  shared bus value
- out_bus  out  DATA_WIDTH  read data; 0 when out_bus_enable=0
- out_bus_enable  out  1  out_bus valid, consumer may sample
- out_bank  out  BANK_WIDTH  current bank register
- out_addr  out  ADDR_WIDTH  current address register
- out_conflict  out  1  sticky: read and write requested same cycle

## Operation
- Registers: bank, addr, rd_data, state, conflict. RAM contents not reset.
- Reset values: out_bank=0, out_addr=0, out_bus=0, out_bus_enable=0, out_conflict=0, state=IDLE.
- FSM states IDLE, RD_OUT.
  - IDLE: in_read_enable (without in_wr_enable) -> RD_OUT, rd_data <= RAM[{bank,addr}].
  - RD_OUT: out_bus_enable=1, out_bus=rd_data. New read this cycle -> stay RD_OUT with new data; otherwise -> IDLE.
- Write: in_wr_enable -> RAM[{bank,addr}] <= in_bus at clock edge; no bus output; state -> IDLE unless in RD_OUT with no new read (still -> IDLE).
- All accesses use bank/addr values held before the edge; an in_addr_wr_enable or in_mbs_wr_enable in the same cycle affects the next access only.
- in_mbs_wr_enable and in_addr_wr_enable together: both latch from the same in_bus value (bank takes low BANK_WIDTH bits).
- in_read_enable and in_wr_enable together: write performed, read suppressed (state -> IDLE), out_conflict set; cleared only by reset.
- Read-after-write same address in consecutive cycles returns the newly written value.

## Timing
- Read latency 1: enable in cycle N, out_bus valid for exactly cycle N+1 (back-to-back reads give valid data every cycle).
- Write, bank and address updates take effect at the edge ending the enable cycle.
- rst_n low asynchronously forces all outputs to reset values, including mid-RD_OUT.

## Configuration
- DATA_MEMORY_AUTO_INC_EN defined: after each completed read or write, addr <= addr+1 (wrap 255->0, bank unchanged); an in_addr_wr_enable in the same cycle takes priority over the increment.
- Not defined: addr changes only via in_addr_wr_enable.

## Structure
- Shared package dmem_pkg: width constants (DATA_WIDTH, ADDR_WIDTH, BANK_WIDTH), FSM state encoding (IDLE, RD_OUT).
- One sub-module: bank_ram, single-port synchronous RAM of 2^(BANK_WIDTH+ADDR_WIDTH) x DATA_WIDTH, registered read, write-first.

## Test plan
- Reset then idle -> out_bank=0, out_addr=0, out_bus=0, out_bus_enable=0, out_conflict=0.
- mbs 0x02, addr 0x10, write 0xA5, read -> next cycle out_bus=0xA5, out_bus_enable=1 for one cycle; bank 0 addr 0x10 still holds prior value.
- addr write 0x20 same cycle as read (addr was 0x10) -> returns data at 0x10; following read returns 0x20 data.
- Read and write together at addr 0x05 with in_bus 0x3C -> RAM[0x05]=0x3C, out_bus_enable stays 0, out_conflict=1 until rst_n.
- With DATA_MEMORY_AUTO_INC_EN, addr 0xFF, bank 1, write 0x11 -> out_addr=0x00, out_bank=1; without, out_addr stays 0xFF.
- rst_n asserted during RD_OUT -> out_bus_enable and out_bus drop to 0 immediately, before next clk edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared widths and FSM encoding for the data memory unit.
// Optional build macro: DATA_MEMORY_AUTO_INC_EN (address post-increment).
package dmem_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int BANK_WIDTH = 2;
  localparam int RAM_AW     = BANK_WIDTH + ADDR_WIDTH;

  // state  | meaning
  // IDLE   | no read data on the bus
  // RD_OUT | read word presented on out_bus this cycle
  typedef enum logic {
    IDLE   = 1'b0,
    RD_OUT = 1'b1
  } dmem_state_e;
endpackage

// File: rtl/bank_ram.sv
// Single-port synchronous RAM spanning all banks; registered read, write-first.
module bank_ram
  import dmem_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = RAM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write-first port: a write also updates the read register with the new word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_unit.sv
// Data memory responder: latches bank/address from the shared bus, performs
// single-port reads/writes and returns read data with a fixed one-cycle latency.
// Optional build macro: DATA_MEMORY_AUTO_INC_EN (address post-increment after
// each read or write; an explicit address load takes priority).
module data_memory_unit
  import dmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_mbs_wr_enable,
  input  logic                  in_addr_wr_enable,
  input  logic                  in_read_enable,
  input  logic                  in_wr_enable,
  input  logic [DATA_WIDTH-1:0] in_bus,
  output logic [DATA_WIDTH-1:0] out_bus,
  output logic                  out_bus_enable,
  output logic [BANK_WIDTH-1:0] out_bank,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_conflict
);

  dmem_state_e           state;
  logic [BANK_WIDTH-1:0] bank;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  conflict;
  logic                  bus_en;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_data;

  // A simultaneous write wins; the read is dropped and flagged as a conflict.
  assign rd_req = in_read_enable & ~in_wr_enable;

  bank_ram #(
    .DW(DATA_WIDTH),
    .AW(RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (in_wr_enable),
    .re    (rd_req),
    .addr  ({bank, addr}),
    .wdata (in_bus),
    .rdata (rd_data)
  );

  // Read FSM: one RD_OUT cycle per accepted read, back-to-back reads stay in RD_OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bus_en <= 1'b0;
    end else begin
      unique case (state)
        IDLE:   if (rd_req)  state <= RD_OUT;
        RD_OUT: if (!rd_req) state <= IDLE;
        default: state <= IDLE;
      endcase
      bus_en <= rd_req;
    end
  end

  // Bank register; only the low bits of the bus select the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (in_mbs_wr_enable) begin
      bank <= in_bus[BANK_WIDTH-1:0];
    end
  end

  // Address register; an explicit load always beats the optional increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (in_addr_wr_enable) begin
      addr <= in_bus[ADDR_WIDTH-1:0];
`ifdef DATA_MEMORY_AUTO_INC_EN
    end else if (in_wr_enable || in_read_enable) begin
      addr <= addr + ADDR_WIDTH'(1);
`endif
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else if (in_read_enable && in_wr_enable) begin
      conflict <= 1'b1;
    end
  end

  // RAM read register is not reset, so gate it with the reset-cleared valid bit.
  assign out_bus        = bus_en ? rd_data : '0;
  assign out_bus_enable = bus_en;
  assign out_bank       = bank;
  assign out_addr       = addr;
  assign out_conflict   = conflict;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit; honours DATA_MEMORY_AUTO_INC_EN.
module tb_data_memory_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mbs_en, addr_en, rd_en, wr_en;
  logic [7:0] bus_in;
  logic [7:0] out_bus;
  logic       out_bus_enable;
  logic [1:0] out_bank;
  logic [7:0] out_addr;
  logic       out_conflict;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_m   [1024];
  bit         valid_m [1024];
  logic [1:0] bank_m;
  logic [7:0] addr_m;
  logic       conflict_m;
  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  data_memory_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_mbs_wr_enable  (mbs_en),
    .in_addr_wr_enable (addr_en),
    .in_read_enable    (rd_en),
    .in_wr_enable      (wr_en),
    .in_bus            (bus_in),
    .out_bus           (out_bus),
    .out_bus_enable    (out_bus_enable),
    .out_bank          (out_bank),
    .out_addr          (out_addr),
    .out_conflict      (out_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  // One bus cycle: update the model, clock the DUT, then compare.
  task automatic step(input logic mbs, input logic aw, input logic rd, input logic wr,
                      input logic [7:0] b);
    logic [9:0] a;
    logic       exp_rd;
    a      = {bank_m, addr_m};
    exp_rd = rd && !wr;
    if (exp_rd) sb_q.push_back(mem_m[a]);
    if (wr) begin
      mem_m[a]   = b;
      valid_m[a] = 1'b1;
    end
    if (rd && wr) conflict_m = 1'b1;
    if (mbs) bank_m = b[1:0];
    if (aw) addr_m = b;
`ifdef DATA_MEMORY_AUTO_INC_EN
    else if (rd || wr) addr_m = addr_m + 8'd1;
`endif
    mbs_en = mbs; addr_en = aw; rd_en = rd; wr_en = wr; bus_in = b;
    @(posedge clk);
    #1;
    mbs_en = 0; addr_en = 0; rd_en = 0; wr_en = 0; bus_in = 8'h00;
    if (exp_rd) begin
      chk("rd_valid", out_bus_enable, 1);
      chk("rd_data", out_bus, sb_q.pop_front());
    end else begin
      chk("idle_valid", out_bus_enable, 0);
      chk("idle_bus", out_bus, 0);
    end
    chk("bank", out_bank, bank_m);
    chk("addr", out_addr, addr_m);
    chk("conflict", out_conflict, conflict_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus"}, out_bus, 0);
    chk({tag, "_valid"}, out_bus_enable, 0);
    chk({tag, "_bank"}, out_bank, 0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_conflict"}, out_conflict, 0);
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0;
    mbs_en = 0; addr_en = 0; rd_en = 0; wr_en = 0; bus_in = 8'h00;
    bank_m = 0; addr_m = 0; conflict_m = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_m[i]   = 8'h00;
      valid_m[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 8'h00);

    // bank 0 addr 0x10 gets a known value
    step(1, 1, 0, 0, 8'h10);
    step(0, 0, 0, 1, 8'h77);
    // bank 2: preload 0x20, then write 0xA5 at 0x10 and read it back
    step(1, 0, 0, 0, 8'h02);
    step(0, 1, 0, 0, 8'h20);
    step(0, 0, 0, 1, 8'h5A);
    step(0, 1, 0, 0, 8'h10);
    step(0, 0, 0, 1, 8'hA5);
    step(0, 1, 0, 0, 8'h10);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // bank 0 addr 0x10 still holds its earlier value
    step(1, 1, 0, 0, 8'h10);
    step(0, 0, 1, 0, 8'h00);
    // address load in the same cycle as a read affects the next read only
    step(1, 0, 0, 0, 8'h02);
    step(0, 1, 0, 0, 8'h10);
    step(0, 1, 1, 0, 8'h20);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // read-after-write on the same address in consecutive cycles
    step(0, 1, 0, 0, 8'h30);
    step(0, 1, 0, 1, 8'h30);
    step(0, 0, 1, 0, 8'hC3);
    // same-address write then read, data path value check
    step(0, 1, 0, 0, 8'h31);
    step(0, 1, 0, 1, 8'h31);
    step(0, 0, 1, 0, 8'h00);
    // read+write conflict at 0x05
    step(0, 1, 0, 0, 8'h05);
    step(0, 0, 1, 1, 8'h3C);
    step(0, 1, 0, 0, 8'h05);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // address wrap / hold at 0xFF in bank 1
    step(1, 0, 0, 0, 8'h01);
    step(0, 1, 0, 0, 8'hFF);
    step(0, 0, 0, 1, 8'h11);
    step(0, 0, 0, 0, 8'h00);

    // randomized mix over a small address window
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom_range(8'h40, 8'h4F));
      step(1, 1, 0, 0, b);
      if (valid_m[{b[1:0], b}] && ($urandom_range(0, 1) == 1))
        step(0, 0, 1, 0, 8'h00);
      else
        step(0, 0, 0, 1, 8'($urandom_range(0, 255)));
    end
    step(0, 0, 0, 0, 8'h00);

    // asynchronous reset while read data is on the bus
    step(1, 0, 0, 0, 8'h02);
    step(0, 1, 0, 0, 8'h20);
    step(0, 0, 1, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bank_m = 0; addr_m = 0; conflict_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 8'h00);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
